uart_rx_stage: RTL and testbench

Serial receive front end that feeds the team's byte FIFO from its write side. Synchronises the asynchronous rx pin and generates a 16x oversampling baud tick internally. Recovers 8N1-style frames LSB-first and presents each good byte with a one-cycle write pulse that connects directly to the FIFO's wr/w_data. Flags framing errors and overruns, where overrun means a byte completed while the FIFO was full.

---
 rtl/uart_rx_stage.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_stage: 16x-oversampled 8N1 serial receiver feeding a byte FIFO   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_rx_stage #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 651,
    parameter int DVSR_W  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            fifo_full,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_wr,
    output logic            frame_err,
    output logic            overrun,
    output logic            rx_busy
);

    localparam int c_S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int c_N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [c_S_W-1:0]  c_S_MID       = c_S_W'(7);
    localparam logic [c_S_W-1:0]  c_S_DATA_LAST = c_S_W'(15);
    localparam logic [c_S_W-1:0]  c_S_STOP_LAST = c_S_W'(SB_TICK - 1);
    localparam logic [c_N_W-1:0]  c_N_LAST      = c_N_W'(DBIT - 1);
    localparam logic [DVSR_W-1:0] c_BAUD_LAST   = DVSR_W'(DVSR - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            r_state, w_state_next;
    logic [c_S_W-1:0]  r_s, w_s_next;
    logic [c_N_W-1:0]  r_n, w_n_next;
    logic [DBIT-1:0]   r_shift, w_shift_next;
    logic [DBIT-1:0]   r_rx_data, w_rx_data_next;
    logic              r_rx_wr, w_rx_wr_next;
    logic              r_frame_err, w_frame_err_next;
    logic              r_overrun, w_overrun_next;
    logic              r_rx_busy;
    logic              r_rx_meta, r_rx_s;
    logic [DVSR_W-1:0] r_baud_cnt;
    logic              w_tick;

    // Two-flop synchroniser, preset to the idle-high line level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick = (r_baud_cnt == c_BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_wr     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_rx_busy   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_s         <= w_s_next;
            r_n         <= w_n_next;
            r_shift     <= w_shift_next;
            r_rx_data   <= w_rx_data_next;
            r_rx_wr     <= w_rx_wr_next;
            r_frame_err <= w_frame_err_next;
            r_overrun   <= w_overrun_next;
            r_rx_busy   <= (w_state_next != ST_IDLE);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_s_next         = r_s;
        w_n_next         = r_n;
        w_shift_next     = r_shift;
        w_rx_data_next   = r_rx_data;
        w_rx_wr_next     = 1'b0;
        w_frame_err_next = 1'b0;
        w_overrun_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Start edge is taken immediately, independent of the tick phase
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                    w_s_next     = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s == c_S_MID) begin
                        if (!r_rx_s) begin
                            w_state_next = ST_DATA;
                            w_s_next     = '0;
                            w_n_next     = '0;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s == c_S_DATA_LAST) begin
                        w_s_next     = '0;
                        w_shift_next = {r_rx_s, r_shift[DBIT-1:1]};
                        if (r_n == c_N_LAST) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s == c_S_STOP_LAST) begin
                        w_state_next = ST_IDLE;
                        if (r_rx_s) begin
                            w_rx_data_next = r_shift;
                            w_rx_wr_next   = !fifo_full;
                            w_overrun_next = fifo_full;
                        end else begin
                            w_frame_err_next = 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_wr     = r_rx_wr;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign rx_busy   = r_rx_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_stage: directed bench for uart_rx_stage with DVSR = 4         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_rx_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] rx_data;
    logic       rx_wr, frame_err, overrun, rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] wr_q[$];
    int         wr_t[$];
    int         wr_hi = 0, ferr_rise = 0, ferr_hi = 0, ovr_rise = 0, ovr_hi = 0;
    logic       prev_ferr = 1'b0, prev_ovr = 1'b0, prev_wr = 1'b0;
    logic       multi_hot = 1'b0, wr_while_busy = 1'b0;
    logic       busy_all;

    uart_rx_stage #(
        .DBIT   (8),
        .SB_TICK(16),
        .DVSR   (4),
        .DVSR_W (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .fifo_full(fifo_full),
        .rx_data  (rx_data),
        .rx_wr    (rx_wr),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse logger: records every write and counts pulse starts versus high cycles
    always @(negedge clk) begin
        prev_wr   <= rx_wr;
        prev_ferr <= frame_err;
        prev_ovr  <= overrun;
        if (rx_wr) begin
            wr_hi <= wr_hi + 1;
            if (!prev_wr) begin
                wr_q.push_back(rx_data);
                wr_t.push_back(cyc);
            end
            if (rx_busy) wr_while_busy <= 1'b1;
        end
        if (frame_err) begin
            ferr_hi <= ferr_hi + 1;
            if (!prev_ferr) ferr_rise <= ferr_rise + 1;
        end
        if (overrun) begin
            ovr_hi <= ovr_hi + 1;
            if (!prev_ovr) ovr_rise <= ovr_rise + 1;
        end
        if ((32'(rx_wr) + 32'(frame_err) + 32'(overrun)) > 1) multi_hot <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame of 64 clocks per bit; a bad stop bit is low for 48 clocks,
    // long enough to cover the stop sample, then idles so the next start
    // candidate is cleanly rejected.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        rx = 1'b0;
        repeat (32) @(negedge clk);
        busy_all &= rx_busy;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (32) @(negedge clk);
            busy_all &= rx_busy;
            repeat (32) @(negedge clk);
        end
        if (stop_ok) begin
            rx = 1'b1;
            repeat (64) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (48) @(negedge clk);
            rx = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int gap;
        repeat (5) @(negedge clk);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_wr", 32'(rx_wr), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_rx_busy", 32'(rx_busy), 32'd0);
        reset = 1'b0;
        idle(20);

        // Good frame
        busy_all = 1'b1;
        send_frame(8'hA5, 1'b1);
        idle(10);
        chk("t1_wr_count", 32'(wr_q.size()), 32'd1);
        chk("t1_data", 32'(wr_q[0]), 32'hA5);
        chk("t1_rx_data_hold", 32'(rx_data), 32'hA5);
        chk("t1_wr_one_cycle", 32'(wr_hi), 32'd1);
        chk("t1_no_ferr", 32'(ferr_rise), 32'd0);
        chk("t1_no_ovr", 32'(ovr_rise), 32'd0);
        chk("t1_busy_in_frame", 32'(busy_all), 32'd1);
        chk("t1_busy_low_at_wr", 32'(wr_while_busy), 32'd0);
        chk("t1_busy_after", 32'(rx_busy), 32'd0);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(10);
        chk("t2_wr_count", 32'(wr_q.size()), 32'd4);
        chk("t2_data0", 32'(wr_q[1]), 32'h00);
        chk("t2_data1", 32'(wr_q[2]), 32'hFF);
        chk("t2_data2", 32'(wr_q[3]), 32'h3C);
        gap = wr_t[2] - wr_t[1];
        chk("t2_gap01", 32'(gap >= 636 && gap <= 644), 32'd1);
        gap = wr_t[3] - wr_t[2];
        chk("t2_gap12", 32'(gap >= 636 && gap <= 644), 32'd1);

        // Framing error
        send_frame(8'h5A, 1'b0);
        idle(100);
        chk("t3_ferr_count", 32'(ferr_rise), 32'd1);
        chk("t3_ferr_one_cycle", 32'(ferr_hi), 32'd1);
        chk("t3_no_wr", 32'(wr_q.size()), 32'd4);
        chk("t3_rx_data_kept", 32'(rx_data), 32'h3C);
        chk("t3_busy_after", 32'(rx_busy), 32'd0);

        // Overrun
        fifo_full = 1'b1;
        send_frame(8'h81, 1'b1);
        idle(10);
        fifo_full = 1'b0;
        chk("t4_ovr_count", 32'(ovr_rise), 32'd1);
        chk("t4_ovr_one_cycle", 32'(ovr_hi), 32'd1);
        chk("t4_no_wr", 32'(wr_q.size()), 32'd4);
        chk("t4_rx_data", 32'(rx_data), 32'h81);
        chk("t4_no_ferr", 32'(ferr_rise), 32'd1);

        // Glitch rejection: 20-clock low pulse is gone before the mid-start sample
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_busy_in_start", 32'(rx_busy), 32'd1);
        idle(100);
        chk("t5_busy_idle", 32'(rx_busy), 32'd0);
        chk("t5_no_wr", 32'(wr_q.size()), 32'd4);
        chk("t5_no_ferr", 32'(ferr_rise), 32'd1);
        chk("t5_no_ovr", 32'(ovr_rise), 32'd1);

        // Reset in the middle of data bit 4 of 0xC3, then line released
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (8'hC3 >> i) & 8'h01;
            repeat (64) @(negedge clk);
        end
        rx = 1'b0;
        repeat (32) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        chk("t6_rst_rx_data", 32'(rx_data), 32'h00);
        chk("t6_rst_rx_wr", 32'(rx_wr), 32'd0);
        chk("t6_rst_frame_err", 32'(frame_err), 32'd0);
        chk("t6_rst_overrun", 32'(overrun), 32'd0);
        chk("t6_rst_rx_busy", 32'(rx_busy), 32'd0);
        idle(700);
        chk("t6_no_wr", 32'(wr_q.size()), 32'd4);
        chk("t6_no_ferr", 32'(ferr_rise), 32'd1);
        chk("t6_no_ovr", 32'(ovr_rise), 32'd1);
        chk("t6_busy_idle", 32'(rx_busy), 32'd0);
        send_frame(8'h7E, 1'b1);
        idle(10);
        chk("t6_wr_count", 32'(wr_q.size()), 32'd5);
        chk("t6_data", 32'(wr_q[4]), 32'h7E);
        chk("t6_rx_data_hold", 32'(rx_data), 32'h7E);

        chk("exclusive_pulses", 32'(multi_hot), 32'd0);
        chk("wr_one_cycle_all", 32'(wr_hi), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
